uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter among NUM_REQ byte requesters. It sits between the requesters (console, status, debug sources) and the transmitter. For each frame it captures one requester's byte, issues a single-cycle tx_start and holds the byte stable, waits for tx_done, then inserts an optional inter-frame gap. One frame is in flight at a time.

---
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional frame watchdog is built when UART_ARB_WDOG_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BITS   = 8,
  parameter int GAP_CYCLES  = 0,
  parameter int WDOG_CYCLES = 200000,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_byte,
  input  logic                           tx_done,
  output logic                           busy,
  output logic [GW-1:0]                  grant_id
`ifdef UART_ARB_WDOG_EN
  ,
  output logic                           wdog_err
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [1:0]           state;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        sel_id;
  logic [GCW-1:0]       gap_cnt;
  logic                 frame_end;
  logic                 wdog_hit;
  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*DATA_BITS +: DATA_BITS];
  end

  // Scan downward so the candidate closest after last_grant is written last and wins.
  always_comb begin
    logic [GW-1:0] cand;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_id = '0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) sel_id = cand;
    end
  end

`ifdef UART_ARB_WDOG_EN
  localparam int WCW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WCW-1:0] wdog_cnt;

  assign wdog_hit = (state == WAIT) && (wdog_cnt == WCW'(WDOG_CYCLES - 1));

  // tx_done on the limit cycle closes the frame normally and suppresses the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_hit && !tx_done;
      if (state == START)     wdog_cnt <= '0;
      else if (state == WAIT) wdog_cnt <= wdog_cnt + WCW'(1);
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  assign frame_end = (state == WAIT) && (tx_done || wdog_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_byte    <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      gap_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        IDLE: begin
          if (|req_valid) begin
            tx_byte  <= req_bytes[sel_id];
            grant_id <= sel_id;
            state    <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (frame_end) begin
            last_grant <= grant_id;
            gap_cnt    <= GCW'(GAP_CYCLES);
            state      <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        default: begin
          gap_cnt <= gap_cnt - GCW'(1);
          if (gap_cnt <= GCW'(1)) state <= IDLE;
        end
      endcase
    end
  end

  assign tx_start = (state == START);
  assign busy     = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (state == START) req_ready[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut0 has no gap, dut1 has a 5-cycle gap.
// The watchdog scenario is compiled in with UART_ARB_WDOG_EN.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  valid = '0;
  logic [31:0] data = '0;
  logic        done = 1'b0;
  logic [3:0]  ready;
  logic        start;
  logic [7:0]  byte_o;
  logic        busy;
  logic [1:0]  gid;

  logic [3:0]  v1 = '0;
  logic [31:0] d1 = '0;
  logic        done1 = 1'b0;
  logic [3:0]  ready1;
  logic        start1;
  logic [7:0]  byte1;
  logic        busy1;
  logic [1:0]  gid1;

`ifdef UART_ARB_WDOG_EN
  logic        wdog;
  logic        wdog1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .GAP_CYCLES(0), .WDOG_CYCLES(50)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_data(data), .req_ready(ready),
    .tx_start(start), .tx_byte(byte_o), .tx_done(done), .busy(busy), .grant_id(gid)
`ifdef UART_ARB_WDOG_EN
    , .wdog_err(wdog)
`endif
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .GAP_CYCLES(5), .WDOG_CYCLES(50)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_data(d1), .req_ready(ready1),
    .tx_start(start1), .tx_byte(byte1), .tx_done(done1), .busy(busy1), .grant_id(gid1)
`ifdef UART_ARB_WDOG_EN
    , .wdog_err(wdog1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input bit which, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      @(negedge clk);
      ok = which ? start1 : start;
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int lat, err_k, err_cnt, start_k;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_byte", byte_o, 0);
    check("rst_ready", ready, 0);
    check("rst_gid", gid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Single request from requester 0
    valid = 4'b0001;
    data  = 32'h0000_0055;
    wait_start(0, 10, ok);
    check("t1_start_seen", ok, 1);
    check("t1_ready", ready, 4'b0001);
    check("t1_byte", byte_o, 8'h55);
    check("t1_gid", gid, 0);
    check("t1_busy", busy, 1);
    valid = 4'b0000;
    @(negedge clk);
    check("t1_start_pulse", start, 0);
    check("t1_ready_pulse", ready, 0);
    check("t1_byte_hold", byte_o, 8'h55);
    repeat (98) @(negedge clk);
    check("t1_busy_wait", busy, 1);
    pulse_done();
    check("t1_busy_done", busy, 0);

    // Round-robin with all four continuously valid, from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b1111;
    data  = 32'hA3A2_A1A0;
    for (int i = 0; i < 8; i++) begin
      wait_start(0, 10, ok);
      check($sformatf("rr%0d_start_seen", i), ok, 1);
      check($sformatf("rr%0d_byte", i), byte_o, 8'hA0 + 8'(i % 4));
      check($sformatf("rr%0d_ready", i), ready, 32'(4'b0001 << (i % 4)));
      check($sformatf("rr%0d_gid", i), gid, i % 4);
      @(negedge clk);
      pulse_done();
    end
    valid = 4'b0000;

    // Stray tx_done in IDLE
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (start || busy) lat++;
    end
    check("stray_done_idle", lat, 0);

    // Frame from requester 2; a 1-cycle request during WAIT must not be captured
    valid = 4'b0100;
    data  = 32'h00C2_0000;
    wait_start(0, 10, ok);
    check("t3_start_seen", ok, 1);
    check("t3_gid", gid, 2);
    valid = 4'b0000;
    @(negedge clk);
    valid = 4'b0001;
    data  = 32'h0000_00EE;
    @(negedge clk);
    valid = 4'b0000;
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (start || !busy) lat++;
    end
    check("t3_wait_no_change", lat, 0);
    check("t3_byte_hold", byte_o, 8'hC2);
    pulse_done();
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (start || busy) lat++;
    end
    check("t3_no_capture", lat, 0);

    // Reset mid-WAIT; last_grant=2 so requester 1 is next by wrap-around
    valid = 4'b0010;
    data  = 32'h0000_B100;
    wait_start(0, 10, ok);
    check("t4_start_seen", ok, 1);
    check("t4_gid", gid, 1);
    valid = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    valid = 4'b1000;
    data  = 32'hD300_0000;
    #1;
    check("t4_async_start", start, 0);
    check("t4_async_busy", busy, 0);
    check("t4_async_byte", byte_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(0, 10, ok);
    check("t4_post_start_seen", ok, 1);
    check("t4_post_gid", gid, 3);
    check("t4_post_ready", ready, 4'b1000);
    check("t4_post_byte", byte_o, 8'hD3);
    valid = 4'b0000;
    @(negedge clk);
    pulse_done();

    // Inter-frame gap of 5 on dut1: next tx_start 7 cycles after tx_done
    v1 = 4'b0001;
    d1 = 32'h0000_0011;
    wait_start(1, 10, ok);
    check("gap_first_start_seen", ok, 1);
    v1 = 4'b0010;
    d1 = 32'h0000_2200;
    @(negedge clk);
    done1 = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) done1 = 1'b0;
      if (k == 3) check("gap_busy", busy1, 1);
      if (start1 && lat == 0) lat = k;
    end
    check("gap_latency", lat, 7);
    check("gap_gid", gid1, 1);
    check("gap_byte", byte1, 8'h22);
    v1 = 4'b0000;

`ifdef UART_ARB_WDOG_EN
    // Watchdog: no tx_done; error 50 cycles after WAIT entry, then requester 1 is granted
    valid = 4'b0001;
    data  = 32'h0000_0077;
    wait_start(0, 10, ok);
    check("wd_start_seen", ok, 1);
    check("wd_gid0", gid, 0);
    valid = 4'b0010;
    data  = 32'h0000_8800;
    err_k = 0;
    err_cnt = 0;
    start_k = 0;
    for (int k = 1; k <= 80 && start_k == 0; k++) begin
      @(negedge clk);
      if (wdog) begin
        err_cnt++;
        if (err_k == 0) err_k = k;
      end
      if (start) start_k = k;
    end
    check("wd_err_cycle", err_k, 51);
    check("wd_err_width", err_cnt, 1);
    check("wd_next_start", start_k, 52);
    check("wd_next_gid", gid, 1);
    check("wd_next_byte", byte_o, 8'h88);
    valid = 4'b0000;

    // tx_done on the limit cycle wins
    err_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 50) done = 1'b1;
      if (k == 51) done = 1'b0;
      if (wdog) err_cnt++;
    end
    check("wd_done_wins", err_cnt, 0);
    check("wd_done_busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
